// File: rtl/pan_pkg.sv
// Shared types and constants for the multi-channel auto-panner LFO.
package pan_pkg;

  typedef enum logic [1:0] {SINE, TRI, SQUARE, SAW} wave_t;
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] PAN_CENTER = 16'h4000;
  localparam logic [15:0] PAN_FULL   = 16'h7FFF;

endpackage

// File: rtl/pan_wave_gen.sv
// LFO waveform generator: sine from ROM, other shapes computed from the address.
// All shapes leave one cycle after the address, so the computed ones are registered.
module pan_wave_gen
  import pan_pkg::*;
#(
  parameter string ROM_FILE = "sine.mem",
  parameter int    ADDR_W   = 12
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  input  wave_t              wave,
  output logic signed [15:0] w
);

  logic signed [15:0] sine_q, shape_d, shape_q;
  logic [15:0]        u;
  logic [14:0]        fold;
  wave_t              wave_q;

  rom #(.ROM_FILE(ROM_FILE), .ADDR_W(ADDR_W), .DATA_W(16)) u_rom (
    .clk  (clk),
    .addr (addr),
    .q    (sine_q)
  );

  always_comb begin
    u       = 16'(addr) << (16 - ADDR_W);
    fold    = u[15] ? ~u[14:0] : u[14:0];
    shape_d = '0;
    case (wave)
      SQUARE:  shape_d = u[15] ? 16'sh8000 : 16'sh7FFF;
      SAW:     shape_d = u ^ 16'h8000;
      TRI:     shape_d = {fold, 1'b0} - 16'h8000;
      default: shape_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    wave_q  <= wave;
    shape_q <= shape_d;
  end

  assign w = (wave_q == SINE) ? sine_q : shape_q;

endmodule

// File: rtl/rom.sv
// Synchronous-read sine ROM, one full period over 2^ADDR_W entries.
// The table is built at elaboration; an empty ROM_FILE name leaves it blank.
module rom #(
  parameter string ROM_FILE = "sine.mem",
  parameter int    ADDR_W   = 12,
  parameter int    DATA_W   = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH_N = 1 << ADDR_W;

  // Bhaskara rational approximation of one sine half-period, mirrored for the other half.
  function automatic logic [DATA_W-1:0] sine_at(input int i);
    longint h, j, p, v;
    h = longint'(DEPTH_N / 2);
    j = longint'(i) % h;
    p = j * (h - j);
    v = (((longint'(1) <<< (DATA_W - 1)) - 1) * 16 * p) / (5 * h * h - 4 * p);
    return (i < DEPTH_N / 2) ? DATA_W'(v) : DATA_W'(-v);
  endfunction

  logic [DATA_W-1:0] tbl [DEPTH_N];

  for (genvar i = 0; i < DEPTH_N; i++) begin : g_tbl
    assign tbl[i] = (ROM_FILE != "") ? sine_at(i) : '0;
  end

  always_ff @(posedge clk) q <= tbl[addr];

endmodule

// File: rtl/auto_panner_lfo.sv
// Multi-channel LFO auto-panner: per-TICK phase step, N_CH gains streamed one per cycle.
//   state | meaning
//   IDLE  | waiting for TICK; outputs hold
//   RUN   | frame in flight: channels issued, then pipeline drained
module auto_panner_lfo
  import pan_pkg::*;
#(
  parameter int    N_CH     = 2,
  parameter int    PHASE_W  = 24,
  parameter int    ADDR_W   = 12,
  parameter string ROM_FILE = "sine.mem",
  localparam int   CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               TICK,
  input  logic               EN,
  input  logic [PHASE_W-1:0] RATE,
  input  logic [1:0]         WAVE,
  input  logic [15:0]        DEPTH,
  input  logic [ADDR_W-1:0]  SPREAD,
  output logic [15:0]        PAN_OUT,
  output logic [15:0]        PAN_R,
  output logic [CH_W-1:0]    PAN_CH,
  output logic               PAN_VALID,
  output logic               BUSY,
  output logic               OVERRUN
);

  localparam int CNT_W = $clog2(N_CH + 2);

  state_t              state, state_nxt;
  logic [PHASE_W-1:0]  phase, phase_nxt;
  logic [CNT_W-1:0]    run_cnt;
  logic [CH_W:0]       iss_ch;
  logic [ADDR_W-1:0]   off, spread_q, addr_d, a_addr;
  wave_t               wave_q, a_wave;
  logic [15:0]         depth_q;
  logic                en_q, accept, issue;
  logic                a_v, r_v;
  logic [CH_W-1:0]     a_ch, r_ch;
  logic signed [15:0]  w;
  logic signed [32:0]  prod, pan_sum;
  logic [16:0]         unused_pan_hi;

  assign accept = TICK && (state == IDLE);
  assign issue  = (state == RUN) && (iss_ch < (CH_W + 1)'(N_CH));
  assign BUSY   = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (TICK) state_nxt = RUN;
      RUN:     if (run_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Channel 0 is addressed in the TICK cycle itself from the not-yet-registered phase.
  always_comb begin
    phase_nxt = EN ? phase + RATE : '0;
    if (accept) addr_d = phase_nxt[PHASE_W-1 -: ADDR_W];
    else        addr_d = phase[PHASE_W-1 -: ADDR_W] + off;
  end

  pan_wave_gen #(.ROM_FILE(ROM_FILE), .ADDR_W(ADDR_W)) u_wave (
    .clk  (CLK),
    .addr (a_addr),
    .wave (a_wave),
    .w    (w)
  );

  always_comb begin
    prod    = $signed({{17{w[15]}}, w}) * $signed({17'b0, depth_q});
    pan_sum = ((prod >>> 16) >>> 1) + 33'sd16384;
  end

  assign unused_pan_hi = pan_sum[32:16];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase     <= '0;
      run_cnt   <= '0;
      iss_ch    <= '0;
      off       <= '0;
      spread_q  <= '0;
      wave_q    <= SINE;
      depth_q   <= '0;
      en_q      <= 1'b0;
      a_v       <= 1'b0;
      a_ch      <= '0;
      a_addr    <= '0;
      a_wave    <= SINE;
      r_v       <= 1'b0;
      r_ch      <= '0;
      PAN_VALID <= 1'b0;
      PAN_OUT   <= PAN_CENTER;
      PAN_CH    <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      if (accept) begin
        phase    <= phase_nxt;
        wave_q   <= wave_t'(WAVE);
        depth_q  <= DEPTH;
        spread_q <= SPREAD;
        en_q     <= EN;
        off      <= SPREAD;
        iss_ch   <= (CH_W + 1)'(1);
        run_cnt  <= CNT_W'(N_CH + 1);
      end else if (state == RUN) begin
        run_cnt <= run_cnt - 1'b1;
        if (issue) begin
          off    <= off + spread_q;
          iss_ch <= iss_ch + 1'b1;
        end
      end
      if (TICK && (state == RUN)) OVERRUN <= 1'b1;

      a_v    <= accept || issue;
      a_ch   <= accept ? '0 : iss_ch[CH_W-1:0];
      a_addr <= addr_d;
      a_wave <= accept ? wave_t'(WAVE) : wave_q;
      r_v    <= a_v;
      r_ch   <= a_ch;

      PAN_VALID <= r_v;
      if (r_v) begin
        PAN_OUT <= en_q ? pan_sum[15:0] : PAN_CENTER;
        PAN_CH  <= r_ch;
      end
    end
  end

  assign PAN_R = PAN_FULL - PAN_OUT;

endmodule

// File: tb/tb_auto_panner_lfo.sv
// Self-checking bench for auto_panner_lfo (N_CH=2, PHASE_W=24, ADDR_W=12).
module tb_auto_panner_lfo;

  localparam int TOL = 32;

  logic        clk = 1'b0;
  logic        reset, tick, en;
  logic [23:0] rate;
  logic [1:0]  wave;
  logic [15:0] depth;
  logic [11:0] spread;
  logic [15:0] pan_out, pan_r;
  logic [0:0]  pan_ch;
  logic        pan_valid, busy, overrun;

  int passed = 0;
  int total  = 0;
  int m_phase = 0;

  always #5 clk = ~clk;

  auto_panner_lfo #(.N_CH(2), .PHASE_W(24), .ADDR_W(12), .ROM_FILE("sine.mem")) dut (
    .CLK       (clk),
    .RESET     (reset),
    .TICK      (tick),
    .EN        (en),
    .RATE      (rate),
    .WAVE      (wave),
    .DEPTH     (depth),
    .SPREAD    (spread),
    .PAN_OUT   (pan_out),
    .PAN_R     (pan_r),
    .PAN_CH    (pan_ch),
    .PAN_VALID (pan_valid),
    .BUSY      (busy),
    .OVERRUN   (overrun)
  );

  // Expected left gain for ROM address a, from the waveform definitions and scaling rules.
  function automatic int exp_pan(int a, int wv, int d, bit e);
    longint u, wl, s;
    if (!e) return 16384;
    u = longint'(a) * 16;
    case (wv)
      0:       wl = longint'(int'(32767.0 * $sin(6.283185307179586 * a / 4096.0)));
      1:       wl = (u < 32768) ? 2 * u - 32768 : 2 * (65535 - u) - 32768;
      2:       wl = (u < 32768) ? 32767 : -32768;
      default: wl = u - 32768;
    endcase
    s = (wl * d) >>> 16;
    return int'((s >>> 1) + 16384);
  endfunction

  task automatic check(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_near(string tag, int obs, int exp, int tol);
    total++;
    assert ((obs - exp <= tol) && (exp - obs <= tol)) passed++;
    else $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
  endtask

  task automatic check_pan(string tag, int ex, bit near);
    if (near) begin
      check_near({tag, "_l"}, int'(pan_out), ex, TOL);
      check_near({tag, "_r"}, int'(pan_r), 32767 - ex, TOL);
    end else begin
      check({tag, "_l"}, int'(pan_out), ex);
      check({tag, "_r"}, int'(pan_r), 32767 - ex);
    end
  endtask

  // One full frame with exact cycle timing; inputs are scrambled after TICK to prove latching.
  task automatic run_frame(input int r, input bit e, input int wv, input int d, input int sp,
                           output int got0, output int got1);
    int a0, a1, ex0, ex1;
    bit near;
    m_phase = e ? (m_phase + r) % (1 << 24) : 0;
    a0   = m_phase >> 12;
    a1   = (a0 + sp) % 4096;
    ex0  = exp_pan(a0, wv, d, e);
    ex1  = exp_pan(a1, wv, d, e);
    near = e && (wv == 0) && (d != 0);
    @(negedge clk);
    rate = 24'(r); en = e; wave = 2'(wv); depth = 16'(d); spread = 12'(sp); tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    rate = 24'($urandom); en = 1'($urandom); wave = 2'($urandom);
    depth = 16'($urandom); spread = 12'($urandom);
    check("busy_t1", int'(busy), 1);
    check("valid_t1", int'(pan_valid), 0);
    @(negedge clk);
    check("valid_t2", int'(pan_valid), 0);
    @(negedge clk);
    check("valid_ch0", int'(pan_valid), 1);
    check("pan_ch0", int'(pan_ch), 0);
    check_pan("gain_ch0", ex0, near);
    got0 = int'(pan_out);
    @(negedge clk);
    check("valid_ch1", int'(pan_valid), 1);
    check("pan_ch1", int'(pan_ch), 1);
    check("busy_last", int'(busy), 1);
    check_pan("gain_ch1", ex1, near);
    got1 = int'(pan_out);
    @(negedge clk);
    check("busy_done", int'(busy), 0);
    check("valid_done", int'(pan_valid), 0);
    check_pan("gain_hold", ex1, near);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g0, g1, cnt, a0, ex0;
    reset = 1'b1; tick = 1'b0; en = 1'b0; rate = '0; wave = '0; depth = '0; spread = '0;
    repeat (3) @(negedge clk);
    check("rst_pan", int'(pan_out), 'h4000);
    check("rst_pan_r", int'(pan_r), 'h3FFF);
    check("rst_ch", int'(pan_ch), 0);
    check("rst_valid", int'(pan_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (pan_valid) cnt++;
    end
    check("idle_no_valid", cnt, 0);

    run_frame('h123456, 1'b0, 2, 'hFFFF, 'h123, g0, g1);
    check("en0_ch0", g0, 'h4000);
    check("en0_ch1", g1, 'h4000);

    run_frame('h400000, 1'b1, 2, 'hFFFF, 'h800, g0, g1);
    check("sq_ch0", g0, 'h7FFF);
    check("sq_ch1", g1, 'h0000);

    run_frame(0, 1'b0, 0, 0, 0, g0, g1);
    run_frame('h800000, 1'b1, 1, 'hFFFF, 0, g0, g1);
    check("tri1_ch0", g0, 'h7FFE);
    check("tri1_ch1", g1, 'h7FFE);
    run_frame('h800000, 1'b1, 1, 'hFFFF, 0, g0, g1);
    check("tri2_ch0", g0, 'h0000);
    check("tri2_ch1", g1, 'h0000);

    for (int wv = 0; wv < 4; wv++) begin
      repeat (2) begin
        run_frame(int'($urandom_range(0, 'hFFFFFF)), 1'b1, wv, 0,
                  int'($urandom_range(0, 'hFFF)), g0, g1);
        check("d0_ch0", g0, 'h4000);
        check("d0_ch1", g1, 'h4000);
      end
    end

    // Frozen LFO: two frames at RATE=0 must land on the same gains.
    run_frame('h3A5000, 1'b1, 3, 'hFFFF, 'h155, g0, g1);
    run_frame(0, 1'b1, 3, 'hFFFF, 'h155, g0, g1);

    for (int i = 0; i < 24; i++) begin
      int r, d;
      r = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 'hFFFFFF));
      d = ($urandom_range(0, 3) == 0) ? 'hFFFF : int'($urandom_range(0, 'hFFFF));
      run_frame(r, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), d,
                int'($urandom_range(0, 'hFFF)), g0, g1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Stray TICK during a frame: frame unchanged, phase advanced once, OVERRUN sticky.
    m_phase = (m_phase + 'h1F3000) % (1 << 24);
    a0 = m_phase >> 12;
    @(negedge clk);
    rate = 24'h1F3000; en = 1'b1; wave = 2'd3; depth = 16'hFFFF; spread = 12'h400; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("ovr_busy", int'(busy), 1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("ovr_valid0", int'(pan_valid), 1);
    check_pan("ovr_ch0", exp_pan(a0, 3, 'hFFFF, 1'b1), 1'b0);
    check("ovr_flag", int'(overrun), 1);
    @(negedge clk);
    check("ovr_ch1_id", int'(pan_ch), 1);
    check_pan("ovr_ch1", exp_pan((a0 + 'h400) % 4096, 3, 'hFFFF, 1'b1), 1'b0);
    @(negedge clk);
    check("ovr_valid_end", int'(pan_valid), 0);
    check("ovr_sticky", int'(overrun), 1);
    run_frame('h0A0000, 1'b1, 3, 'hFFFF, 'h0, g0, g1);
    check("ovr_sticky2", int'(overrun), 1);

    // Reset in the middle of a frame aborts it.
    m_phase = (m_phase + 'h222000) % (1 << 24);
    a0  = m_phase >> 12;
    ex0 = exp_pan(a0, 1, 'hC000, 1'b1);
    @(negedge clk);
    rate = 24'h222000; en = 1'b1; wave = 2'd1; depth = 16'hC000; spread = 12'h321; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("abort_valid0", int'(pan_valid), 1);
    check_pan("abort_ch0", ex0, 1'b0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_valid", int'(pan_valid), 0);
    check("abort_overrun", int'(overrun), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ch", int'(pan_ch), 0);
    check_pan("abort_pan", 'h4000, 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (pan_valid) cnt++;
    end
    check("abort_no_ch1", cnt, 0);
    m_phase = 0;
    run_frame('h600000, 1'b1, 3, 'hFFFF, 'h100, g0, g1);
    check("post_rst_ch0", g0, exp_pan('h600, 3, 'hFFFF, 1'b1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/auto_panner_lfo.md
# auto_panner_lfo

Multi-channel LFO auto-panner: a parametrised successor to the single-sine panner. Runs a phase-accumulator LFO that advances once per audio sample tick. For each of N_CH voices it emits a pan gain, using a selectable waveform, depth scaling and a per-channel phase spread. Gains leave as a time-multiplexed stream (one channel per CLK), where the mixer applies them as complementary left/right coefficients.

## Interface
Parameters:
- N_CH, 2, number of panned channels; CH_W = max(1, $clog2(N_CH))
- PHASE_W, 24, phase accumulator width
- ADDR_W, 12, sine ROM address width; top ADDR_W phase bits index the ROM
- ROM_FILE, "sine.mem", signed 16-bit sine table, 2^ADDR_W entries

Ports:
- CLK in 1: the single clock.
- RESET in 1: synchronous, active-high.
- TICK in 1: one-CLK sample-rate strobe.
- EN in 1: auto-pan enable; 0 forces the centre gain.
- RATE in PHASE_W: phase increment per TICK.
- WAVE in 2: waveform select. 0 sine, 1 triangle, 2 square, 3 saw.
- DEPTH in 16: unsigned modulation depth; 0xFFFF is full scale.
- SPREAD in ADDR_W: phase offset per channel index.
- PAN_OUT out 16: left gain, range 0x0000..0x7FFF.
- PAN_R out 16: right gain, equal to 0x7FFF - PAN_OUT.
- PAN_CH out CH_W: channel index of the current PAN_OUT.
- PAN_VALID out 1: PAN_OUT, PAN_R and PAN_CH are valid this cycle.
- BUSY out 1: a frame is in progress.
- OVERRUN out 1: sticky; a TICK arrived while BUSY. Cleared only by RESET.

## Operation
- Reset values:
  - phase 0, state IDLE
  - PAN_OUT 0x4000, PAN_R 0x3FFF, PAN_CH 0
  - PAN_VALID 0, BUSY 0, OVERRUN 0
- FSM states are IDLE and RUN.
  - IDLE→RUN on TICK.
  - RUN→IDLE after channel N_CH-1 is output.
- On an accepted TICK:
  - phase ← EN ? phase + RATE : 0, modulo 2^PHASE_W.
  - WAVE, DEPTH, SPREAD and EN are latched for the whole frame.
- Channel k address: a = phase[PHASE_W-1 -: ADDR_W] + k·SPREAD, modulo 2^ADDR_W. This uses the updated phase.
- Waveform w (signed 16). Let u = a left-aligned to 16 bits (zero-padded).
  - sine: ROM[a]
  - square: u[15] ? 0x8000 : 0x7FFF
  - saw: u ^ 0x8000
  - triangle: fold = u[15] ? ~u[14:0] : u[14:0]; w = {fold,1'b0} - 0x8000
- Scaling, in signed 33-bit arithmetic:
  - s = (w · DEPTH) >>> 16
  - PAN_OUT = (s >>> 1) + 0x4000
  - The result is guaranteed to lie in 0x0000..0x7FFF.
- Latched EN=0: every channel outputs 0x4000 / 0x3FFF, and phase is held at 0, so re-enabling starts at phase 0.
- RATE=0 freezes the LFO. DEPTH=0 outputs 0x4000 for every channel.
- TICK while BUSY is ignored: no phase update, current frame undisturbed, OVERRUN←1.
- RESET wins over a simultaneous TICK. RESET mid-frame returns all outputs to reset values on the next edge; no further PAN_VALID pulses from the aborted frame.

## Timing
- TICK sampled high in cycle t.
  - Channel k appears with PAN_VALID=1 and PAN_CH=k in cycle t+3+k, a fixed 3-cycle pipeline.
  - Pipeline stages: address, synchronous ROM read, multiply/register.
- PAN_VALID is high for exactly N_CH consecutive cycles per frame.
- PAN_OUT/PAN_R/PAN_CH hold their last value when PAN_VALID=0.
- BUSY is high in cycles t+1 through t+2+N_CH. A TICK in cycle t+3+N_CH or later is accepted.
- Minimum TICK period is N_CH+3 CLK cycles.

## Structure
- Shared package pan_pkg:
  - wave_t enum: SINE, TRI, SQUARE, SAW
  - state_t: IDLE, RUN
  - constants PAN_CENTER = 16'h4000, PAN_FULL = 16'h7FFF
- One sub-module, pan_wave_gen: wraps the existing rom (ROM_FILE, ADDR_W, 16) plus the waveform select. It takes address and WAVE and delivers w with 1-cycle latency. Shape-select paths are delayed to match the ROM.
- The top level holds the phase accumulator, FSM, channel counter, scaling and output registers.

## Test plan
All scenarios use N_CH=2, PHASE_W=24, ADDR_W=12.
- Reset → PAN_OUT 0x4000, PAN_R 0x3FFF, PAN_VALID/BUSY/OVERRUN 0; no PAN_VALID while TICK stays low.
- EN=0, TICK at t → PAN_VALID at t+3 (ch0) and t+4 (ch1), both 0x4000/0x3FFF; BUSY high t+1..t+4.
- EN=1, WAVE=square, DEPTH=0xFFFF, RATE=0x400000, SPREAD=0x800, one TICK → ch0 0x7FFF / PAN_R 0x0000; ch1 0x0000 / PAN_R 0x7FFF.
- WAVE=triangle, DEPTH=0xFFFF, RATE=0x800000, SPREAD=0 → first TICK 0x7FFE for both channels; second TICK (phase wraps to 0) 0x0000.
- DEPTH=0 with each WAVE value, several TICKs → every output 0x4000.
- Overrun and reset abort:
  - TICK at t, second TICK at t+2 → frame 1 outputs unchanged, phase advanced once, OVERRUN=1.
  - Then RESET at t+3 → PAN_VALID 0 from t+4, OVERRUN 0, no channel-1 output.
